burst_xfer_ctrl: RTL and testbench
==================================

// Module: burst_xfer_ctrl
// PURPOSE
//  Downstream stage of the two-requester grant arbiter. Consumes the registered one-hot grants
//  gnt_0/gnt_1 and moves a burst of len_x+1 data beats from the granted requester to one shared
//  valid/ready sink. Signals burst completion per requester so that requester drops its req.
//  Ignores stale grant cycles caused by the arbiter's two-cycle grant latency.
// PARAMETERS
//  WIDTH    8  data beat width, bits
//  LEN_W    4  burst length field width; bursts are 1..2**LEN_W beats
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low; all state and outputs cleared on assertion
//  gnt_0      in   1      grant to requester 0 (from arbiter)
//  gnt_1      in   1      grant to requester 1 (from arbiter)
//  len_0      in   LEN_W  requester 0 burst length minus one; sampled at burst start
//  len_1      in   LEN_W  requester 1 burst length minus one; sampled at burst start
//  data_0     in   WIDTH  requester 0 current beat (show-ahead)
//  data_1     in   WIDTH  requester 1 current beat (show-ahead)
//  rd_0       out  1      pop strobe to requester 0 = beat accepted by sink
//  rd_1       out  1      pop strobe to requester 1
//  out_valid  out  1      beat valid to sink
//  out_ready  in   1      sink ready
//  out_data   out  WIDTH  beat data = data_<src>
//  out_src    out  1      source of current beat (0/1)
//  out_last   out  1      final beat of burst, qualified by out_valid
//  done_0     out  1      one-cycle pulse: requester 0 burst complete
//  done_1     out  1      one-cycle pulse: requester 1 burst complete
//  err        out  1      one-cycle pulse: protocol fault (both grants high, or grant lost mid-burst)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, src=0; out_valid, rd_x, out_last, done_x, err = 0. out_data follows data_0.
//  States: IDLE, XFER, DONE, REL. Registered state, cnt[LEN_W-1:0], src[0].
//  IDLE: gnt_0|gnt_1 -> src = gnt_0 ? 0 : 1; cnt = len_src; go XFER next edge.
//        gnt_0&gnt_1 -> take requester 0; pulse err.
//  XFER: out_valid=1 (combinational from state); out_data/out_src muxed from src; out_last = (cnt==0).
//        Beat accepted when out_valid&out_ready; rd_src=1 that cycle; cnt decrements.
//        Accept with cnt==0 -> DONE. out_ready low -> hold; data, cnt and last do not change.
//        gnt_src low while in XFER -> abort. Any beat accepted that same cycle is still popped.
//        Pulse err, no done; go REL.
//  DONE: done_src=1 for exactly one cycle; go REL.
//  REL:  wait until gnt_0==0 && gnt_1==0, then IDLE. Absorbs the arbiter's stale grant after req drops.
//  Latency: grant seen at edge N -> out_valid high in cycle N+1. Full burst with ready held high
//   = len+1 cycles in XFER, + 1 DONE, + >=1 REL.
//  Max burst: len=2**LEN_W-1 gives 2**LEN_W beats; cnt never wraps (leaves XFER at 0).
//  Grant switching to the other requester during XFER counts as loss of gnt_src (abort).
//  Reset mid-burst: immediate clear; no done or err pulse; partial burst abandoned.
// STRUCTURE
//  Shared package: state encodings (one-hot, 4 bits: IDLE/XFER/DONE/REL), src encodings SRC0/SRC1.
//  No sub-module required. Optional sub-module burst_beat_cnt (load/decrement/zero flag) if reused.
//  All outputs except out_valid/out_data/out_last/rd_x are registered; those four decode state and src.
// TESTING
//  1 gnt_0 held, len_0=3, out_ready=1: 4 beats D0..D3, src=0, last on 4th; done_0 one cycle later.
//  2 gnt_1, len_1=0, out_ready low 3 cycles then high: out_valid held 3 cycles; data stable;
//    1 beat with last; done_1.
//  3 gnt_0 drops after 2 of 5 beats (len_0=4): err pulse, rd_0 count=2, no done_0; REL then IDLE.
//  4 gnt_0&gnt_1 high in IDLE: err pulse, burst from requester 0.
//  5 gnt_0 stays high 2 cycles after done_0: FSM stays in REL; no second burst.
//    Next grant (gnt_1) serviced normally.
//  6 reset low mid-burst (beat 2 of 8): all outputs 0 asynchronously; after release IDLE,
//    and a new len=15 burst yields 16 beats.

Source files
------------

// File: rtl/burst_xfer_ctrl_pkg.sv
// Shared encodings for the burst transfer controller: one-hot FSM states and
// requester source identifiers.
package burst_xfer_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_XFER = 4'b0010,
        ST_DONE = 4'b0100,
        ST_REL  = 4'b1000
    } state_t;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_t;

endpackage

// File: rtl/burst_xfer_ctrl.sv
// Moves a len+1 beat burst from the granted requester to a shared valid/ready
// sink, signalling completion per requester and flagging grant protocol faults.
module burst_xfer_ctrl
    import burst_xfer_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             gnt_0,
    input  logic             gnt_1,
    input  logic [LEN_W-1:0] len_0,
    input  logic [LEN_W-1:0] len_1,
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    output logic             rd_0,
    output logic             rd_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_last,
    output logic             done_0,
    output logic             done_1,
    output logic             err,
    output logic [3:0]       state_dbg
);

    // Sink handshake: a beat transfers on every rising edge where out_valid and
    // out_ready are both high; while out_ready is low out_data, out_src and
    // out_last stay constant, and out_valid never drops until the beat moves
    // or the burst is aborted by grant loss.

    state_t           state, state_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    src_t             src, src_nx;
    logic             done_0_nx, done_1_nx, err_nx;
    logic             gnt_src;
    logic             accept;

    assign out_valid = (state == ST_XFER);
    assign out_data  = (src == SRC1) ? data_1 : data_0;
    assign out_last  = out_valid && (cnt == '0);
    assign accept    = out_valid && out_ready;
    assign rd_0      = accept && (src == SRC0);
    assign rd_1      = accept && (src == SRC1);
    assign out_src   = src;
    assign state_dbg = state;
    assign gnt_src   = (src == SRC1) ? gnt_1 : gnt_0;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        src_nx    = src;
        done_0_nx = 1'b0;
        done_1_nx = 1'b0;
        err_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_0 || gnt_1) begin
                    // Requester 0 wins a double grant; the fault is still reported.
                    src_nx   = gnt_0 ? SRC0 : SRC1;
                    cnt_nx   = gnt_0 ? len_0 : len_1;
                    err_nx   = gnt_0 && gnt_1;
                    state_nx = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!gnt_src) begin
                    err_nx   = 1'b1;
                    state_nx = ST_REL;
                end else if (accept) begin
                    if (cnt == '0) begin
                        done_0_nx = (src == SRC0);
                        done_1_nx = (src == SRC1);
                        state_nx  = ST_DONE;
                    end else begin
                        cnt_nx = cnt - LEN_W'(1);
                    end
                end
            end
            ST_DONE: state_nx = ST_REL;
            // Stale grants from the arbiter pipeline are swallowed here.
            ST_REL: begin
                if (!gnt_0 && !gnt_1) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            src    <= SRC0;
            done_0 <= 1'b0;
            done_1 <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            src    <= src_nx;
            done_0 <= done_0_nx;
            done_1 <= done_1_nx;
            err    <= err_nx;
        end
    end

endmodule

// File: tb/tb_burst_xfer_ctrl.sv
// Bench for burst_xfer_ctrl: cycle vector table for the protocol corners, then
// randomized bursts scored against a transaction-level expected-beat queue.
module tb_burst_xfer_ctrl;
    import burst_xfer_ctrl_pkg::*;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int MEM_N = 1024;

    logic             clock = 1'b0;
    logic             reset;
    logic             gnt_0, gnt_1;
    logic [LEN_W-1:0] len_0, len_1;
    logic [WIDTH-1:0] data_0, data_1;
    logic             rd_0, rd_1;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_src, out_last;
    logic             done_0, done_1, err;
    logic [3:0]       state_dbg;

    burst_xfer_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clock(clock), .reset(reset), .gnt_0(gnt_0), .gnt_1(gnt_1),
        .len_0(len_0), .len_1(len_1), .data_0(data_0), .data_1(data_1),
        .rd_0(rd_0), .rd_1(rd_1), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .out_last(out_last),
        .done_0(done_0), .done_1(done_1), .err(err), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             g0, g1;
        logic [LEN_W-1:0] l0, l1;
        logic             rdy;
        logic [3:0]       e_state;
        logic             e_valid, e_src, e_last, e_rd0, e_rd1, e_d0, e_d1, e_err;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH-1:0] mem0[MEM_N];
    logic [WIDTH-1:0] mem1[MEM_N];
    int               p0, p1;
    int               n_tests, n_fail;

    function automatic vec_t mk(input logic g0, g1, input int l0, l1, input logic rdy,
                                input state_t st, input logic v, s, l, r0, r1, d0, d1, e);
        vec_t x;
        x.g0 = g0; x.g1 = g1; x.l0 = LEN_W'(l0); x.l1 = LEN_W'(l1); x.rdy = rdy;
        x.e_state = st; x.e_valid = v; x.e_src = s; x.e_last = l;
        x.e_rd0 = r0; x.e_rd1 = r1; x.e_d0 = d0; x.e_d1 = d1; x.e_err = e;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, sample 1 time unit later.
    task automatic drive(input logic g0, g1, input int l0, l1, input logic rdy);
        @(negedge clock);
        gnt_0 = g0; gnt_1 = g1;
        len_0 = LEN_W'(l0); len_1 = LEN_W'(l1);
        out_ready = rdy;
        data_0 = mem0[p0 % MEM_N];
        data_1 = mem1[p1 % MEM_N];
        #1;
    endtask

    task automatic run_burst(input logic r, input int len, input int rdy_pct, input int stale);
        int               base, pops, dones;
        logic [WIDTH+1:0] item;
        logic [WIDTH-1:0] d;
        base = r ? p1 : p0;
        for (int i = 0; i <= len; i++) begin
            d = r ? mem1[(base + i) % MEM_N] : mem0[(base + i) % MEM_N];
            exp_q.push_back({r, (i == len), d});
        end
        pops = 0;
        dones = 0;
        for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
            drive(!r, r, r ? 0 : len, r ? len : 0, ($urandom_range(99) < rdy_pct));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    item = exp_q.pop_front();
                    check("beat", {out_src, out_last, out_data}, item);
                end
            end
            if (r ? rd_1 : rd_0) pops++;
            if (r ? rd_0 : rd_1) check("rd_wrong_src", 1, 0);
            if (rd_0) p0++;
            if (rd_1) p1++;
            if (err) check("burst_err", err, 0);
            if (r ? done_1 : done_0) dones++;
        end
        check("burst_done", dones, 1);
        check("burst_pops", pops, len + 1);
        check("burst_q_empty", exp_q.size(), 0);
        exp_q.delete();
        for (int s = 0; s < stale; s++) begin
            drive(!r, r, 0, 0, 1'b1);
            check("stale_valid", out_valid, 0);
            check("stale_done", r ? done_1 : done_0, 0);
        end
        drive(0, 0, 0, 0, 1'b1);
        check("rel_state", state_dbg, ST_REL);
        drive(0, 0, 0, 0, 1'b1);
        check("idle_state", state_dbg, ST_IDLE);
    endtask

    initial begin
        vec_t v;
        logic r;
        int   pops;
        n_tests = 0; n_fail = 0; p0 = 0; p1 = 0;
        for (int i = 0; i < MEM_N; i++) begin
            mem0[i] = WIDTH'($urandom);
            mem1[i] = WIDTH'($urandom);
        end
        gnt_0 = 0; gnt_1 = 0; len_0 = 0; len_1 = 0; out_ready = 0;
        data_0 = mem0[0]; data_1 = mem1[0];
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_outs", {out_valid, rd_0, rd_1, out_last, done_0, done_1, err, out_src}, 0);
        check("rst_data", out_data, mem0[0]);
        @(negedge clock);
        reset = 1'b1;

        // gnt_0 burst of 4, stale grant held 2 cycles after done
        vecs.push_back(mk(1,0,3,0,1, ST_IDLE,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,3,0,1, ST_XFER,1,0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,3,0,1, ST_XFER,1,0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,3,0,1, ST_XFER,1,0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,3,0,1, ST_XFER,1,0,1,1,0,0,0,0));
        vecs.push_back(mk(1,0,3,0,1, ST_DONE,0,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,3,0,1, ST_REL ,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,3,0,1, ST_REL ,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,3,0,1, ST_IDLE,0,0,0,0,0,0,0,0));
        // gnt_1 single beat, sink stalls 3 cycles
        vecs.push_back(mk(0,1,0,0,0, ST_IDLE,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, ST_XFER,1,1,1,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, ST_XFER,1,1,1,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, ST_XFER,1,1,1,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,1, ST_XFER,1,1,1,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1, ST_DONE,0,1,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1, ST_REL ,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1, ST_IDLE,0,1,0,0,0,0,0,0));
        // double grant in IDLE
        vecs.push_back(mk(1,1,0,5,1, ST_IDLE,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,5,1, ST_XFER,1,0,1,1,0,0,0,1));
        vecs.push_back(mk(0,0,0,5,1, ST_DONE,0,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,5,1, ST_REL ,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,5,1, ST_IDLE,0,0,0,0,0,0,0,0));
        // gnt_0 lost after 2 of 5 beats
        vecs.push_back(mk(1,0,4,0,1, ST_IDLE,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,4,0,1, ST_XFER,1,0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,4,0,1, ST_XFER,1,0,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,4,0,0, ST_XFER,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,4,0,0, ST_REL ,0,0,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,4,0,0, ST_IDLE,0,0,0,0,0,0,0,0));
        // grant switches to requester 1 mid-burst; the beat that cycle is popped
        vecs.push_back(mk(1,0,1,0,1, ST_IDLE,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,1, ST_XFER,1,0,0,1,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,1, ST_REL ,0,0,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,1,0,1, ST_REL ,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,1, ST_IDLE,0,0,0,0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.g0, v.g1, int'(v.l0), int'(v.l1), v.rdy);
            check($sformatf("vec%0d_state", i), state_dbg, v.e_state);
            check($sformatf("vec%0d_outs", i),
                  {out_valid, out_src, out_last, rd_0, rd_1, done_0, done_1, err},
                  {v.e_valid, v.e_src, v.e_last, v.e_rd0, v.e_rd1, v.e_d0, v.e_d1, v.e_err});
            if (v.e_valid)
                check($sformatf("vec%0d_data", i), out_data,
                      v.e_src ? mem1[p1 % MEM_N] : mem0[p0 % MEM_N]);
            if (v.e_rd0) p0++;
            if (v.e_rd1) p1++;
        end

        // reset asserted during beat 3 of an 8-beat burst
        pops = 0;
        drive(1, 0, 7, 0, 1);
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive(1, 0, 7, 0, 1);
            if (pops == 2) break;
            if (rd_0) begin
                p0++;
                pops++;
            end
        end
        check("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_state", state_dbg, ST_IDLE);
        check("mid_rst_outs", {out_valid, rd_0, rd_1, out_last, done_0, done_1, err, out_src}, 0);
        check("mid_rst_data", out_data, mem0[p0 % MEM_N]);
        gnt_0 = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        run_burst(1'b0, 15, 70, 1);

        for (int n = 0; n < 16; n++) begin
            r = 1'($urandom_range(1));
            run_burst(r, $urandom_range(15), $urandom_range(100, 30), $urandom_range(2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
